div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Sequencing controller between the EX stage and the 64-bit iterative divider core for RV64M DIV/DIVU/REM/REMU and the W variants. Accepts one request per valid/ready handshake and resolves special cases locally: divide-by-zero, signed overflow and repeated-operand hits. Otherwise it prepares operands, holds the core's level-sensitive start, and captures, selects and sign-extends the result. Presents the result to writeback via valid/ready and supports pipeline flush.

Parameters:
XLEN, 64, operand/result width (only 64 supported)
TAG_W, 5, width of the destination tag carried with the request

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_funct3  in  3  [0] unsigned, [1] remainder; [2] ignored
req_word  in  1  W variant (32-bit operation)
req_rs1  in  XLEN  dividend
req_rs2  in  XLEN  divisor
req_tag  in  TAG_W  destination tag
flush  in  1  kill in-flight op
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_data  out  XLEN  result
out_tag  out  TAG_W  tag of result
div_start  out  1  core start; level, held high until div_ready
div_signed_dividend  out  1  to core
div_signed_divisor  out  1  to core
div_dividend  out  XLEN  to core
div_divisor  out  XLEN  to core
div_quotient  in  XLEN  from core
div_remainder  in  XLEN  from core
div_ready  in  1  core done

Behaviour:
- Reset: state IDLE; req_ready=1, out_valid=0, div_start=0, out_data=0, out_tag=0, div_* operand outputs=0, cache invalid.
- States: IDLE, BUSY, DONE, DRAIN. req_ready=1 only in IDLE.
- Operand prep: signed=~funct3[0]. Word: a=signed ? sext(rs1[31:0]) : zext(rs1[31:0]); same for b. Non-word: a=rs1, b=rs2.
- Accept in IDLE (req_valid & ~flush) latches prepared a, b, signed, rem and tag. Next state:
  - b==0: DONE. Quotient = all ones; remainder = a.
  - signed & overflow: DONE. Overflow is a==0x8000000000000000 & b==all ones, or for word a==sext(0x80000000) & b==all ones. Quotient = a; remainder = 0.
  - Cache hit: DONE with cached quotient/remainder. Hit = cache valid & a, b, signed and word all equal the cached values.
  - Otherwise: BUSY.
- The three DONE paths above give out_valid the cycle after acceptance.
- BUSY: div_start=1 and div_signed_dividend=div_signed_divisor=signed; operands are stable the whole time. On div_ready=1:
  - capture quotient and remainder into result and cache, and set cache valid;
  - drop div_start and go to DONE. out_valid rises the following cycle.
- Result select: rem ? remainder : quotient. Word results are sext(result[31:0]).
- DONE: out_valid=1; out_data/out_tag are stable until out_ready=1, then go to IDLE. A new request cannot be accepted in the same cycle.
- Flush:
  - IDLE: blocks acceptance that cycle.
  - BUSY: div_start=0 next cycle, go to DRAIN; cache is left unchanged.
  - DONE: drop out_valid and go to IDLE.
  - Flush has priority over div_ready and out_ready in the same cycle.
- DRAIN: exactly one cycle with div_start=0 so the core returns to idle, then IDLE.
- div_start is never reasserted in the cycle immediately after it drops.
- Cache is invalidated only by rst. Special-case paths neither read nor update it.
- rst mid-operation: immediate return to reset values next edge; div_start=0.

Decomposition:
- Shared package div_pkg: state enum (IDLE/BUSY/DONE/DRAIN), funct3 bit-index constants, XLEN, MIN_SIGNED and ALL_ONES constants.
- One natural sub-module, div_operand_prep: combinational extension plus zero/overflow detection. Cache and FSM stay in div_ctrl.
- Bench uses a behavioural divider model with configurable latency, not the RTL core.

Test Plan:
- DIV rs1=100, rs2=-7, word=0, core latency 66 -> div_start high 66 cycles with signed=1; out_data=-14 one cycle after div_ready; then REM on same operands -> cache hit, out_data=2 one cycle after accept, div_start stays 0.
- DIVU rs2=0, rs1=0x1234 -> no div_start; out_data=0xFFFFFFFFFFFFFFFF. REMU same -> out_data=0x1234.
- DIV rs1=0x8000000000000000, rs2=-1 -> out_data=0x8000000000000000; REM -> 0. DIVW rs1=0x80000000, rs2=0xFFFFFFFF -> 0xFFFFFFFF80000000.
- DIVUW rs1=0xFFFFFFFF_FFFFFFFE, rs2=2 -> core dividend 0x00000000FFFFFFFE, signed=0; out_data=0x000000007FFFFFFF. REMW rs1=-7, rs2=2 -> 0xFFFFFFFFFFFFFFFF.
- Flush 10 cycles into BUSY -> div_start low next cycle, one DRAIN cycle, req_ready back after it, no out_valid. Re-issue the same op -> cache miss, full core run.
- out_ready held low 5 cycles in DONE -> out_data/out_tag stable, req_ready=0. out_ready=1 -> IDLE next cycle. Flush and div_ready in the same cycle -> flush wins, no result.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package  : div_pkg
// Purpose  : Shared types and constants for the RV64M divide controller.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int XLEN = 64;

  // funct3 bit positions
  localparam int F3_UNSIGNED = 0;
  localparam int F3_REM      = 1;

  localparam logic [XLEN-1:0] MIN_SIGNED   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_SIGNED_W = {{(XLEN-32){1'b1}}, 1'b1, 31'b0};
  localparam logic [XLEN-1:0] ALL_ONES     = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Sign-extend the low word of a value to full width
  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_operand_prep.sv
`default_nettype none
// ============================================================================
// Module   : div_operand_prep
// Purpose  : Extends request operands for W/non-W ops and flags the
//            divide-by-zero and signed-overflow special cases.
// Revision : 1.0 - initial release
// ============================================================================
module div_operand_prep
  import div_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic            is_signed,
  output logic            is_rem,
  output logic            b_zero,
  output logic            overflow
);

  // funct3[2] only distinguishes M-extension ops upstream; not needed here
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  // Operand extension and special-case detection
  always_comb begin
    is_signed = ~funct3[F3_UNSIGNED];
    is_rem    = funct3[F3_REM];
    if (word) begin
      a = is_signed ? sext32(rs1) : {{(XLEN-32){1'b0}}, rs1[31:0]};
      b = is_signed ? sext32(rs2) : {{(XLEN-32){1'b0}}, rs2[31:0]};
    end else begin
      a = rs1;
      b = rs2;
    end
    b_zero   = (b == '0);
    overflow = is_signed && (b == ALL_ONES) &&
               (a == (word ? MIN_SIGNED_W : MIN_SIGNED));
  end

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Sequences RV64M DIV/DIVU/REM/REMU (+W) between EX and the
//            iterative divider core; resolves divide-by-zero, overflow and
//            repeated-operand hits locally, supports flush.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_start,
  output logic             div_signed_dividend,
  output logic             div_signed_divisor,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  input  logic             div_ready
);
  import div_pkg::*;

  state_t state, state_nxt;

  // Latched request
  logic [XLEN-1:0]  a_q, b_q;
  logic             signed_q, rem_q, word_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  result_q;

  // Last core result, keyed by prepared operands
  logic             cache_valid;
  logic [XLEN-1:0]  cache_a, cache_b, cache_quo, cache_rem;
  logic             cache_signed, cache_word;

  // Prepared request operands
  logic [XLEN-1:0]  p_a, p_b;
  logic             p_signed, p_rem, p_bzero, p_ovf;

  logic accept, cache_hit, core_done;

  div_operand_prep u_prep (
    .funct3    (req_funct3),
    .word      (req_word),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .a         (p_a),
    .b         (p_b),
    .is_signed (p_signed),
    .is_rem    (p_rem),
    .b_zero    (p_bzero),
    .overflow  (p_ovf)
  );

  // Quotient/remainder select with W-variant sign extension
  function automatic logic [XLEN-1:0] select_result(
    input logic            rem,
    input logic            word,
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rmd
  );
    logic [XLEN-1:0] v;
    v = rem ? rmd : quo;
    return word ? sext32(v) : v;
  endfunction

  assign accept    = (state == IDLE) && req_valid && !flush;
  assign cache_hit = cache_valid && (p_a == cache_a) && (p_b == cache_b) &&
                     (p_signed == cache_signed) && (req_word == cache_word);
  // Flush beats a same-cycle core completion
  assign core_done = (state == BUSY) && div_ready && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/start outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_nxt = (p_bzero || p_ovf || cache_hit) ? DONE : BUSY;
      end
      BUSY: begin
        div_start = 1'b1;
        if (flush)          state_nxt = DRAIN;
        else if (div_ready) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_nxt = IDLE;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and result capture (special cases, cache hit, core)
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_q      <= p_a;
        b_q      <= p_b;
        signed_q <= p_signed;
        rem_q    <= p_rem;
        word_q   <= req_word;
        tag_q    <= req_tag;
        if (p_bzero)
          result_q <= select_result(p_rem, req_word, ALL_ONES, p_a);
        else if (p_ovf)
          result_q <= select_result(p_rem, req_word, p_a, '0);
        else if (cache_hit)
          result_q <= select_result(p_rem, req_word, cache_quo, cache_rem);
      end
      if (core_done)
        result_q <= select_result(rem_q, word_q, div_quotient, div_remainder);
    end
  end

  // Cache fill on every completed core run; only reset invalidates it
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_word   <= 1'b0;
      cache_quo    <= '0;
      cache_rem    <= '0;
    end else if (core_done) begin
      cache_valid  <= 1'b1;
      cache_a      <= a_q;
      cache_b      <= b_q;
      cache_signed <= signed_q;
      cache_word   <= word_q;
      cache_quo    <= div_quotient;
      cache_rem    <= div_remainder;
    end
  end

  assign out_data            = result_q;
  assign out_tag             = tag_q;
  assign div_dividend        = a_q;
  assign div_divisor         = b_q;
  assign div_signed_dividend = signed_q;
  assign div_signed_divisor  = signed_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Self-checking bench for div_ctrl with a behavioural divider
//            core of configurable latency and an RV64M reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_funct3 = '0;
  logic             req_word = 1'b0;
  logic [XLEN-1:0]  req_rs1 = '0, req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             div_start, div_signed_dividend, div_signed_divisor;
  logic [XLEN-1:0]  div_dividend, div_divisor;
  logic [XLEN-1:0]  div_quotient = '0, div_remainder = '0;
  logic             div_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int core_lat = 4;
  int core_cnt = 0;

  // Reference cache: prepared operands of the last completed core run
  logic        mc_valid = 1'b0;
  logic [63:0] mc_a = '0, mc_b = '0;
  logic        mc_s = 1'b0, mc_w = 1'b0;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_word(req_word), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .div_start(div_start), .div_signed_dividend(div_signed_dividend),
    .div_signed_divisor(div_signed_divisor), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_ready(div_ready)
  );

  // Behavioural divider core: div_ready pulses in the core_lat-th start cycle
  always @(posedge clk) begin
    if (rst || !div_start) begin
      core_cnt  <= 0;
      div_ready <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == core_lat - 2) begin
        div_ready <= 1'b1;
        if (div_divisor == 0) begin
          div_quotient  <= '0;
          div_remainder <= '0;
        end else if (div_signed_dividend) begin
          div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
          div_remainder <= $signed(div_dividend) % $signed(div_divisor);
        end else begin
          div_quotient  <= div_dividend / div_divisor;
          div_remainder <= div_dividend % div_divisor;
        end
      end else begin
        div_ready <= 1'b0;
      end
    end
  end

  // RV64M architectural result
  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] x, input logic [63:0] y);
    logic uns, rem;
    logic [31:0] x32, y32, q32, r32;
    logic [63:0] q, r;
    uns = f3[0];
    rem = f3[1];
    x32 = x[31:0];
    y32 = y[31:0];
    if (w) begin
      if (y32 == 0) begin q32 = '1; r32 = x32; end
      else if (!uns && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin q32 = x32; r32 = 0; end
      else if (uns) begin q32 = x32 / y32; r32 = x32 % y32; end
      else begin q32 = $signed(x32) / $signed(y32); r32 = $signed(x32) % $signed(y32); end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (y == 0) begin q = '1; r = x; end
      else if (!uns && x == 64'h8000_0000_0000_0000 && y == '1) begin q = x; r = 0; end
      else if (uns) begin q = x / y; r = x % y; end
      else begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); end
    end
    return rem ? r : q;
  endfunction

  function automatic logic [63:0] prep(input logic w, input logic uns, input logic [63:0] x);
    if (!w) return x;
    return uns ? {32'h0, x[31:0]} : {{32{x[31]}}, x[31:0]};
  endfunction

  // Returns 1 when the op must go to the core; records it as a completed run
  function automatic bit model_issue(input logic [2:0] f3, input logic w,
                                     input logic [63:0] x, input logic [63:0] y);
    logic [63:0] a, b;
    logic s;
    s = !f3[0];
    a = prep(w, f3[0], x);
    b = prep(w, f3[0], y);
    if (b == 0) return 0;
    if (s && b == '1 && a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 0;
    if (mc_valid && a == mc_a && b == mc_b && s == mc_s && w == mc_w) return 0;
    mc_valid = 1'b1; mc_a = a; mc_b = b; mc_s = s; mc_w = w;
    return 1;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request from a negedge and wait (bounded) for out_valid
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] x,
                        input logic [63:0] y, input logic [4:0] tag,
                        output logic [63:0] data, output logic [4:0] otag,
                        output int starts, output int waitc, output logic sgn,
                        output logic [63:0] dvd, output logic to);
    int n;
    data = '0; otag = '0; starts = 0; waitc = 0; sgn = 1'b0; dvd = '0; to = 1'b0;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_funct3 = f3; req_word = w; req_rs1 = x; req_rs2 = y; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0; req_rs1 = {$urandom, $urandom}; req_rs2 = {$urandom, $urandom};
    req_funct3 = 3'($urandom); req_word = 1'($urandom);
    waitc = 1;
    while (!out_valid && waitc < 500) begin
      if (div_start) begin
        if (starts == 0) begin sgn = div_signed_dividend; dvd = div_dividend; end
        starts++;
      end
      @(negedge clk);
      waitc++;
    end
    to = !out_valid;
    data = out_data;
    otag = out_tag;
    if (out_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (req_ready !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0) begin miscompares++; $display("FAIL reset_ctl got ready=%b valid=%b start=%b exp 1 0 0", req_ready, out_valid, div_start); end
    vectors++; if (out_data !== 64'h0 || out_tag !== 5'h0) begin miscompares++; $display("FAIL reset_out got data=%h tag=%h exp 0 0", out_data, out_tag); end
    vectors++; if (div_dividend !== 64'h0 || div_divisor !== 64'h0) begin miscompares++; $display("FAIL reset_ops got %h %h exp 0 0", div_dividend, div_divisor); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_div();
    logic [63:0] d, dv; logic [4:0] t; int st, wc; logic sg, to; bit ran;
    core_lat = 66;
    ran = model_issue(3'b100, 1'b0, 64'd100, -64'sd7);
    run_op(3'b100, 1'b0, 64'd100, -64'sd7, 5'd3, d, t, st, wc, sg, dv, to);
    vectors++; if (to !== 1'b0 || ran !== 1'b1) begin miscompares++; $display("FAIL div_timeout got to=%b ran=%b exp 0 1", to, ran); end
    vectors++; if (st !== 66 || sg !== 1'b1) begin miscompares++; $display("FAIL div_start got cycles=%0d signed=%b exp 66 1", st, sg); end
    vectors++; if (d !== 64'hFFFF_FFFF_FFFF_FFF2 || t !== 5'd3) begin miscompares++; $display("FAIL div_data got %h tag %0d exp fffffffffffffff2 tag 3", d, t); end
    vectors++; if (wc !== 67) begin miscompares++; $display("FAIL div_latency got %0d exp 67", wc); end
    ran = model_issue(3'b110, 1'b0, 64'd100, -64'sd7);
    run_op(3'b110, 1'b0, 64'd100, -64'sd7, 5'd4, d, t, st, wc, sg, dv, to);
    vectors++; if (st !== 0 || wc !== 1 || ran !== 1'b0) begin miscompares++; $display("FAIL rem_hit got starts=%0d wait=%0d exp 0 1", st, wc); end
    vectors++; if (d !== 64'd2 || t !== 5'd4) begin miscompares++; $display("FAIL rem_hit_data got %h tag %0d exp 2 tag 4", d, t); end
  endtask

  task automatic test_special();
    logic [63:0] d, dv; logic [4:0] t; int st, wc; logic sg, to; bit ran;
    logic [2:0]  f3s [5] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100};
    logic        ws  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] xs  [5] = '{64'h1234, 64'h1234, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000};
    logic [63:0] ys  [5] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF};
    logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000};
    core_lat = 5;
    for (int i = 0; i < 5; i++) begin
      ran = model_issue(f3s[i], ws[i], xs[i], ys[i]);
      run_op(f3s[i], ws[i], xs[i], ys[i], 5'(i + 8), d, t, st, wc, sg, dv, to);
      vectors++; if (d !== exp[i] || st !== 0 || wc !== 1 || ran !== 1'b0) begin miscompares++; $display("FAIL special_%0d got data=%h starts=%0d wait=%0d exp %h 0 1", i, d, st, wc, exp[i]); end
    end
  endtask

  task automatic test_word();
    logic [63:0] d, dv; logic [4:0] t; int st, wc; logic sg, to; bit ran;
    core_lat = 8;
    ran = model_issue(3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2);
    run_op(3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd20, d, t, st, wc, sg, dv, to);
    vectors++; if (dv !== 64'h0000_0000_FFFF_FFFE || sg !== 1'b0 || st !== 8) begin miscompares++; $display("FAIL divuw_core got dividend=%h signed=%b starts=%0d exp 00000000fffffffe 0 8", dv, sg, st); end
    vectors++; if (d !== 64'h0000_0000_7FFF_FFFF) begin miscompares++; $display("FAIL divuw_data got %h exp 000000007fffffff", d); end
    ran = model_issue(3'b110, 1'b1, -64'sd7, 64'd2);
    run_op(3'b110, 1'b1, -64'sd7, 64'd2, 5'd21, d, t, st, wc, sg, dv, to);
    vectors++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF || st !== (ran ? 8 : 0)) begin miscompares++; $display("FAIL remw_data got %h starts=%0d exp ffffffffffffffff", d, st); end
  endtask

  task automatic test_flush();
    logic [63:0] d, dv; logic [4:0] t; int st, wc, n; logic sg, to; bit ran;
    // flush in IDLE blocks acceptance
    req_valid = 1'b1; req_funct3 = 3'b101; req_word = 1'b0; req_rs1 = 64'd999; req_rs2 = 64'd13; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    vectors++; if (req_ready !== 1'b1 || div_start !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_idle got ready=%b start=%b valid=%b exp 1 0 0", req_ready, div_start, out_valid); end
    // flush 10 cycles into BUSY
    core_lat = 30;
    req_valid = 1'b1; req_funct3 = 3'b101; req_word = 1'b0; req_rs1 = 64'd123457; req_rs2 = 64'd31; req_tag = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    vectors++; if (div_start !== 1'b1) begin miscompares++; $display("FAIL flush_busy_pre got start=%b exp 1", div_start); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (div_start !== 1'b0 || req_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drain got start=%b ready=%b valid=%b exp 0 0 0", div_start, req_ready, out_valid); end
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0) begin miscompares++; $display("FAIL flush_idle_back got ready=%b valid=%b start=%b exp 1 0 0", req_ready, out_valid, div_start); end
    ran = model_issue(3'b101, 1'b0, 64'd123457, 64'd31);
    run_op(3'b101, 1'b0, 64'd123457, 64'd31, 5'd10, d, t, st, wc, sg, dv, to);
    vectors++; if (st !== 30 || ran !== 1'b1 || d !== 64'd3982 || to !== 1'b0) begin miscompares++; $display("FAIL flush_reissue got starts=%0d data=%h exp 30 %h", st, d, 64'd3982); end
    // flush coincident with div_ready
    core_lat = 12;
    req_valid = 1'b1; req_funct3 = 3'b100; req_word = 1'b0; req_rs1 = 64'd777777; req_rs2 = 64'd11; req_tag = 5'd12;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!div_ready && n < 100) begin @(negedge clk); n++; end
    vectors++; if (div_ready !== 1'b1) begin miscompares++; $display("FAIL flush_rdy_wait got div_ready=%b exp 1", div_ready); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (out_valid !== 1'b0 || div_start !== 1'b0) begin miscompares++; $display("FAIL flush_rdy got valid=%b start=%b exp 0 0", out_valid, div_start); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_rdy_idle got valid=%b ready=%b exp 0 1", out_valid, req_ready); end
    ran = model_issue(3'b100, 1'b0, 64'd777777, 64'd11);
    run_op(3'b100, 1'b0, 64'd777777, 64'd11, 5'd13, d, t, st, wc, sg, dv, to);
    vectors++; if (st !== 12 || ran !== 1'b1 || d !== 64'd70707) begin miscompares++; $display("FAIL flush_rdy_reissue got starts=%0d data=%h exp 12 %h", st, d, 64'd70707); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d, dv; logic [4:0] t; int st, wc, bad; logic sg, to; bit ran;
    core_lat = 6;
    out_ready = 1'b0;
    ran = model_issue(3'b101, 1'b0, 64'd5000, 64'd7);
    run_op(3'b101, 1'b0, 64'd5000, 64'd7, 5'd17, d, t, st, wc, sg, dv, to);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 64'd714 || out_tag !== 5'd17 || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++; if (bad !== 0 || to !== 1'b0) begin miscompares++; $display("FAIL hold_stable got %0d unstable cycles data=%h tag=%0d exp 0 %h 17", bad, out_data, out_tag, 64'd714); end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release got valid=%b ready=%b exp 0 1", out_valid, req_ready); end
    // flush while waiting in DONE
    out_ready = 1'b0;
    ran = model_issue(3'b101, 1'b0, 64'd1, 64'd0);
    run_op(3'b101, 1'b0, 64'd1, 64'd0, 5'd18, d, t, st, wc, sg, dv, to);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0 || req_ready !== 1'b1 || to !== 1'b0) begin miscompares++; $display("FAIL flush_done got valid=%b ready=%b exp 0 1", out_valid, req_ready); end
  endtask

  task automatic test_reset_cache();
    logic [63:0] d, dv; logic [4:0] t; int st, wc; logic sg, to; bit ran;
    core_lat = 7;
    ran = model_issue(3'b100, 1'b0, 64'd9001, 64'd17);
    run_op(3'b100, 1'b0, 64'd9001, 64'd17, 5'd1, d, t, st, wc, sg, dv, to);
    // mid-operation reset on another op
    req_valid = 1'b1; req_funct3 = 3'b101; req_word = 1'b0; req_rs1 = 64'd55555; req_rs2 = 64'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mc_valid = 1'b0;
    vectors++; if (div_start !== 1'b0 || req_ready !== 1'b1 || out_data !== 64'h0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset got start=%b ready=%b data=%h exp 0 1 0", div_start, req_ready, out_data); end
    ran = model_issue(3'b100, 1'b0, 64'd9001, 64'd17);
    run_op(3'b100, 1'b0, 64'd9001, 64'd17, 5'd2, d, t, st, wc, sg, dv, to);
    vectors++; if (st !== 7 || ran !== 1'b1 || d !== 64'd529) begin miscompares++; $display("FAIL reset_cache got starts=%0d data=%h exp 7 %h", st, d, 64'd529); end
  endtask

  task automatic test_random();
    logic [63:0] d, dv, x, y, e; logic [4:0] t, tg; int st, wc; logic sg, to, w, uns, rem; bit ran;
    x = 64'd1; y = 64'd1; w = 1'b0; uns = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        x = pick(); y = pick(); w = 1'($urandom); uns = 1'($urandom);
      end
      rem = 1'($urandom);
      tg = 5'($urandom);
      core_lat = $urandom_range(2, 12);
      e = ref_result({1'($urandom), rem, uns}, w, x, y);
      ran = model_issue({1'b0, rem, uns}, w, x, y);
      run_op({1'($urandom), rem, uns}, w, x, y, tg, d, t, st, wc, sg, dv, to);
      vectors++; if (d !== e || t !== tg || to !== 1'b0) begin miscompares++; $display("FAIL rand_%0d_data got %h tag %0d exp %h tag %0d (w=%b u=%b r=%b x=%h y=%h)", i, d, t, e, tg, w, uns, rem, x, y); end
      vectors++; if (st !== (ran ? core_lat : 0) || wc !== (ran ? core_lat + 1 : 1)) begin miscompares++; $display("FAIL rand_%0d_timing got starts=%0d wait=%0d exp %0d %0d", i, st, wc, ran ? core_lat : 0, ran ? core_lat + 1 : 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_div();
    test_special();
    test_word();
    test_flush();
    test_backpressure();
    test_reset_cache();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
